// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the load/store path.
// Data has fixed priority, only one transaction is outstanding, and a response timeout is enforced.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    input  logic            if_flush_i,
    output logic [DW-1:0]   if_rdata_o,
    output logic            if_valid_o,
    output logic            if_stall_o,

    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [DW/8-1:0] d_be_i,
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_wdata_i,
    output logic [DW-1:0]   d_rdata_o,
    output logic            d_valid_o,
    output logic            d_stall_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i,

    output logic            err_o
);

    // state   | meaning
    // IDLE    | no transaction outstanding; arbitrate and present a request
    // WAIT_D  | data access granted, waiting for mem_rvalid_i
    // WAIT_I  | fetch granted, waiting for mem_rvalid_i (may be dropped by flush)

    localparam int BW = DW / 8;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_D = 2'd1,
        ST_WAIT_I = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          drop;
    logic          sel_d;
    logic          in_wait;
    logic          timeout_hit;
    logic          resp_done;

    assign sel_d       = d_req_i;
    assign in_wait     = (state == ST_WAIT_D) || (state == ST_WAIT_I);
    assign timeout_hit = in_wait && !mem_rvalid_i && (cnt == CNT_LAST);
    assign resp_done   = mem_rvalid_i || timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter restarts from zero on every entry into a wait state.
    always_ff @(posedge clk) begin
        if (reset || !in_wait) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop <= 1'b0;
        end else if ((state == ST_WAIT_I) && !resp_done) begin
            drop <= drop | if_flush_i;
        end else begin
            drop <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if ((d_req_i || if_req_i) && mem_gnt_i) begin
                    state_nxt = sel_d ? ST_WAIT_D : ST_WAIT_I;
                end
            end
            ST_WAIT_D, ST_WAIT_I: begin
                if (resp_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = {BW{1'b1}};
        mem_addr_o  = if_addr_i;
        mem_wdata_o = '0;
        d_valid_o   = 1'b0;
        if_valid_o  = 1'b0;
        err_o       = 1'b0;

        if (sel_d) begin
            mem_we_o    = d_we_i;
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end

        // Outputs are masked during reset so a late response cannot leak out.
        if (!reset) begin
            mem_req_o  = (state == ST_IDLE) && (d_req_i || if_req_i);
            d_valid_o  = (state == ST_WAIT_D) && mem_rvalid_i;
            if_valid_o = (state == ST_WAIT_I) && mem_rvalid_i && !drop && !if_flush_i;
            err_o      = timeout_hit;
        end
    end

    assign d_rdata_o  = mem_rdata_i;
    assign if_rdata_o = mem_rdata_i;
    assign d_stall_o  = d_req_i && !d_valid_o;
    assign if_stall_o = if_req_i && !if_valid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, delayed grant, flush, timeout, reset.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_flush_i;
    logic [DW-1:0] if_rdata_o;
    logic          if_valid_o;
    logic          if_stall_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [3:0]    d_be_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic [DW-1:0] d_rdata_o;
    logic          d_valid_o;
    logic          d_stall_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o), .d_stall_o(d_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_i = 0; if_addr_i = '0; if_flush_i = 0;
        d_req_i = 0; d_we_i = 0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        clear_inputs();
        cyc(); cyc();
        if_req_i = 1; d_req_i = 1; mem_rvalid_i = 1; mem_gnt_i = 1;
        #2;
        n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %0b want 0", mem_req_o); end
        n_cmp++; if (d_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_d_valid: got %0b want 0", d_valid_o); end
        n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_if_valid: got %0b want 0", if_valid_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0b want 0", err_o); end
        n_cmp++; if (if_stall_o !== 1'b1) begin n_bad++; $display("FAIL rst_if_stall: got %0b want 1", if_stall_o); end
        n_cmp++; if (d_stall_o !== 1'b1) begin n_bad++; $display("FAIL rst_d_stall: got %0b want 1", d_stall_o); end
        cyc();
        clear_inputs();
        reset = 0;
        #2;
        n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL idle_mem_req: got %0b want 0", mem_req_o); end
        mem_rvalid_i = 1;
        #1;
        n_cmp++; if (d_valid_o !== 1'b0 || if_valid_o !== 1'b0) begin n_bad++; $display("FAIL idle_rvalid_ignored: got d=%0b i=%0b want 0 0", d_valid_o, if_valid_o); end
        cyc();
        mem_rvalid_i = 0;
    endtask

    task automatic test_fetch();
        if_req_i = 1; if_addr_i = 32'h100; mem_gnt_i = 1;
        #2;
        n_cmp++; if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL fetch_req: got %0b want 1", mem_req_o); end
        n_cmp++; if (mem_addr_o !== 32'h100) begin n_bad++; $display("FAIL fetch_addr: got %h want 00000100", mem_addr_o); end
        n_cmp++; if (mem_we_o !== 1'b0 || mem_be_o !== 4'hF || mem_wdata_o !== 32'h0) begin n_bad++; $display("FAIL fetch_ctl: got we=%0b be=%h wd=%h want 0 f 0", mem_we_o, mem_be_o, mem_wdata_o); end
        n_cmp++; if (if_stall_o !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_pre: got %0b want 1", if_stall_o); end
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h00500093;
        #2;
        n_cmp++; if (if_valid_o !== 1'b1) begin n_bad++; $display("FAIL fetch_valid: got %0b want 1", if_valid_o); end
        n_cmp++; if (if_rdata_o !== 32'h00500093) begin n_bad++; $display("FAIL fetch_rdata: got %h want 00500093", if_rdata_o); end
        n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL fetch_wait_req: got %0b want 0", mem_req_o); end
        n_cmp++; if (if_stall_o !== 1'b0 || d_valid_o !== 1'b0) begin n_bad++; $display("FAIL fetch_done: got stall=%0b dval=%0b want 0 0", if_stall_o, d_valid_o); end
        cyc();
        if_req_i = 0; mem_rvalid_i = 0;
        #2;
        n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL fetch_pulse: got %0b want 0", if_valid_o); end
        cyc();
    endtask

    task automatic test_priority();
        d_req_i = 1; d_we_i = 0; d_be_i = 4'hF; d_addr_i = 32'h2000;
        if_req_i = 1; if_addr_i = 32'h104; mem_gnt_i = 1;
        #2;
        n_cmp++; if (mem_addr_o !== 32'h2000) begin n_bad++; $display("FAIL prio_addr: got %h want 00002000", mem_addr_o); end
        n_cmp++; if (if_stall_o !== 1'b1 || d_stall_o !== 1'b1) begin n_bad++; $display("FAIL prio_stalls: got i=%0b d=%0b want 1 1", if_stall_o, d_stall_o); end
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0011;
        #2;
        n_cmp++; if (d_valid_o !== 1'b1 || if_valid_o !== 1'b0) begin n_bad++; $display("FAIL prio_d_first: got d=%0b i=%0b want 1 0", d_valid_o, if_valid_o); end
        n_cmp++; if (d_rdata_o !== 32'h11) begin n_bad++; $display("FAIL prio_d_rdata: got %h want 00000011", d_rdata_o); end
        n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL prio_no_b2b: got %0b want 0", mem_req_o); end
        cyc();
        d_req_i = 0; mem_rvalid_i = 0; mem_gnt_i = 1;
        #2;
        n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104) begin n_bad++; $display("FAIL prio_fetch_next: got req=%0b addr=%h want 1 00000104", mem_req_o, mem_addr_o); end
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0022;
        #2;
        n_cmp++; if (if_valid_o !== 1'b1 || d_valid_o !== 1'b0) begin n_bad++; $display("FAIL prio_fetch_valid: got i=%0b d=%0b want 1 0", if_valid_o, d_valid_o); end
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_store_delayed_gnt();
        d_req_i = 1; d_we_i = 1; d_be_i = 4'b0011; d_addr_i = 32'h3000; d_wdata_i = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_cmp++; if (mem_req_o !== 1'b1 || d_stall_o !== 1'b1) begin n_bad++; $display("FAIL st_hold_%0d: got req=%0b stall=%0b want 1 1", i, mem_req_o, d_stall_o); end
            cyc();
        end
        mem_gnt_i = 1;
        #2;
        n_cmp++; if (mem_we_o !== 1'b1 || mem_be_o !== 4'b0011) begin n_bad++; $display("FAIL st_ctl: got we=%0b be=%b want 1 0011", mem_we_o, mem_be_o); end
        n_cmp++; if (mem_wdata_o !== 32'hDEADBEEF || mem_addr_o !== 32'h3000) begin n_bad++; $display("FAIL st_data: got wd=%h a=%h want deadbeef 00003000", mem_wdata_o, mem_addr_o); end
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1;
        #2;
        n_cmp++; if (d_valid_o !== 1'b1 || d_stall_o !== 1'b0) begin n_bad++; $display("FAIL st_ack: got val=%0b stall=%0b want 1 0", d_valid_o, d_stall_o); end
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_flush();
        if_req_i = 1; if_addr_i = 32'h200; mem_gnt_i = 1;
        cyc();
        mem_gnt_i = 0; if_flush_i = 1;
        #2;
        n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL fl_pulse_valid: got %0b want 0", if_valid_o); end
        cyc();
        if_flush_i = 0;
        cyc();
        mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
        #2;
        n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL fl_dropped: got %0b want 0", if_valid_o); end
        n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL fl_wait_req: got %0b want 0", mem_req_o); end
        cyc();
        mem_rvalid_i = 0; if_addr_i = 32'h204;
        #2;
        n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h204) begin n_bad++; $display("FAIL fl_back_idle: got req=%0b addr=%h want 1 00000204", mem_req_o, mem_addr_o); end
        mem_gnt_i = 1;
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1; if_flush_i = 1;
        #2;
        n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL fl_coincident: got %0b want 0", if_valid_o); end
        cyc();
        clear_inputs();
        #2;
        if_req_i = 1;
        #1;
        n_cmp++; if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL fl_coinc_idle: got %0b want 1", mem_req_o); end
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_timeout();
        d_req_i = 1; d_we_i = 0; d_be_i = 4'hF; d_addr_i = 32'h4000; mem_gnt_i = 1;
        cyc();
        mem_gnt_i = 0;
        for (int i = 1; i <= 3; i++) begin
            #2;
            n_cmp++; if (err_o !== 1'b0 || mem_req_o !== 1'b0) begin n_bad++; $display("FAIL to_early_%0d: got err=%0b req=%0b want 0 0", i, err_o, mem_req_o); end
            cyc();
        end
        #2;
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL to_err: got %0b want 1", err_o); end
        n_cmp++; if (d_valid_o !== 1'b0) begin n_bad++; $display("FAIL to_no_valid: got %0b want 0", d_valid_o); end
        cyc();
        mem_gnt_i = 1;
        #2;
        n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4000 || err_o !== 1'b0) begin n_bad++; $display("FAIL to_retry: got req=%0b addr=%h err=%0b want 1 00004000 0", mem_req_o, mem_addr_o, err_o); end
        cyc();
        mem_gnt_i = 0; mem_rvalid_i = 1;
        #2;
        n_cmp++; if (d_valid_o !== 1'b1 || err_o !== 1'b0) begin n_bad++; $display("FAIL to_retry_done: got val=%0b err=%0b want 1 0", d_valid_o, err_o); end
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_reset_mid();
        if_req_i = 1; if_addr_i = 32'h300; mem_gnt_i = 1;
        cyc();
        mem_gnt_i = 0; reset = 1;
        cyc();
        reset = 0; if_req_i = 0; mem_rvalid_i = 1;
        #2;
        n_cmp++; if (if_valid_o !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL rm_late_rvalid: got val=%0b err=%0b want 0 0", if_valid_o, err_o); end
        cyc();
        mem_rvalid_i = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_cmp++; if (err_o !== 1'b0 || mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rm_quiet_%0d: got err=%0b req=%0b want 0 0", i, err_o, mem_req_o); end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store_delayed_gnt();
        test_flush();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
